control_fsm: RTL and testbench

- Multi-cycle fetch/decode/sequencing controller that drives `data_path`.
- Fetches 16-bit instructions from instruction memory over a req/valid handshake and holds `instruct_reg`.
- Decodes `instruct_reg[3:0]` into the datapath control lines and owns the 8-bit PC.
- Consumes `jump_signal` and the datapath result to select the next PC.

---
 rtl/proc_pkg.sv | 46 ++++
 rtl/op_decoder.sv | 39 +++
 rtl/control_fsm.sv | 118 +++++++++++
 tb/tb_control_fsm.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// Shared opcode map, FSM state encoding and widths for the fetch/decode/sequencing controller.
package proc_pkg;
  localparam int PC_W    = 8;
  localparam int INSTR_W = 16;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SLL  = 4'd1;
  localparam logic [3:0] OP_SRL  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_LI   = 4'd6;
  localparam logic [3:0] OP_LW   = 4'd7;
  localparam logic [3:0] OP_SW   = 4'd8;
  localparam logic [3:0] OP_ADDI = 4'd9;
  localparam logic [3:0] OP_BEQZ = 4'd10;
  localparam logic [3:0] OP_BEQ  = 4'd11;
  localparam logic [3:0] OP_J    = 4'd12;
  localparam logic [3:0] OP_HALT = 4'd15;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_UPDATE = 3'd4,
    ST_HALT   = 3'd5
  } state_t;

  // Which strobe (if any) an opcode fires in EXEC/MEM.
  typedef enum logic [2:0] {
    CLS_NONE  = 3'd0,
    CLS_REGW  = 3'd1,
    CLS_LOAD  = 3'd2,
    CLS_STORE = 3'd3,
    CLS_HALT  = 3'd4
  } strobe_cls_t;

  typedef struct packed {
    logic regdest;
    logic alusrc;
    logic memtoreg;
    logic branch;
    logic jump;
  } levels_t;
endpackage

// File: rtl/op_decoder.sv
// Combinational opcode decode: datapath levels, strobe class and illegal flag.
// Zero latency; no flow control.
module op_decoder
  import proc_pkg::*;
(
  input  logic [3:0]  opcode,
  output levels_t     levels,
  output strobe_cls_t cls,
  output logic        illegal
);
  always_comb begin
    levels  = '0;
    cls     = CLS_NONE;
    illegal = 1'b0;
    case (opcode)
      OP_ADD, OP_SLL, OP_SRL, OP_SUB, OP_AND, OP_OR: begin
        levels.regdest = 1'b1;
        cls            = CLS_REGW;
      end
      OP_LI, OP_ADDI: begin
        levels.alusrc = 1'b1;
        cls           = CLS_REGW;
      end
      OP_LW: begin
        levels.alusrc   = 1'b1;
        levels.memtoreg = 1'b1;
        cls             = CLS_LOAD;
      end
      OP_SW: begin
        levels.alusrc = 1'b1;
        cls           = CLS_STORE;
      end
      OP_BEQZ, OP_BEQ: levels.branch = 1'b1;
      OP_J:            levels.jump   = 1'b1;
      OP_HALT:         cls = CLS_HALT;
      default:         illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/control_fsm.sv
// Fetch/decode/sequencing controller: 4 cycles per instruction, 5 for lw/sw, plus fetch wait.
// Fetch stalls in FETCH with imem_req held until imem_valid; HALT is left only by reset.
module control_fsm #(
  parameter int              PC_W     = proc_pkg::PC_W,
  parameter int              INSTR_W  = proc_pkg::INSTR_W,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_valid,
  input  logic               jump_signal,
  input  logic [INSTR_W-1:0] dp_out,
  output logic               imem_req,
  output logic [PC_W-1:0]    PC,
  output logic [INSTR_W-1:0] instruct_reg,
  output logic               regdest,
  output logic               alusrc,
  output logic               memtoreg,
  output logic               branch,
  output logic               jump,
  output logic               regwrite,
  output logic               memread,
  output logic               memwrite,
  output logic               halted,
  output logic               illegal_op,
  output logic [CNT_W-1:0]   retired_count
);
  import proc_pkg::*;

  localparam logic [PC_W-1:0]  PC_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t      state_q, state_d;
  levels_t     lvl_q, dec_lvl;
  strobe_cls_t dec_cls;
  logic        dec_illegal;
  logic        redirect;
  logic        dp_unused;

  assign dp_unused = ^dp_out[INSTR_W-1:PC_W];

  op_decoder u_dec (
    .opcode  (instruct_reg[3:0]),
    .levels  (dec_lvl),
    .cls     (dec_cls),
    .illegal (dec_illegal)
  );

  // Only branch/jump ops may redirect; jump_signal can be stale otherwise.
  assign redirect = jump_signal && (lvl_q.branch || lvl_q.jump);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= ST_FETCH;
      PC            <= RESET_PC;
      instruct_reg  <= '0;
      retired_count <= '0;
      lvl_q         <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_FETCH:  if (imem_valid) instruct_reg <= imem_rdata;
        ST_DECODE: lvl_q <= dec_lvl;
        ST_EXEC:   if (dec_cls == CLS_HALT) retired_count <= retired_count + CNT_ONE;
        ST_UPDATE: begin
          lvl_q         <= '0;
          retired_count <= retired_count + CNT_ONE;
          PC            <= redirect ? dp_out[PC_W-1:0] : PC + PC_ONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d    = state_q;
    imem_req   = 1'b0;
    regwrite   = 1'b0;
    memread    = 1'b0;
    memwrite   = 1'b0;
    halted     = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req = reset;
        if (imem_valid) state_d = ST_DECODE;
      end
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC: begin
        regwrite   = (dec_cls == CLS_REGW);
        memread    = (dec_cls == CLS_LOAD);
        memwrite   = (dec_cls == CLS_STORE);
        illegal_op = dec_illegal;
        case (dec_cls)
          CLS_LOAD, CLS_STORE: state_d = ST_MEM;
          CLS_HALT:            state_d = ST_HALT;
          default:             state_d = ST_UPDATE;
        endcase
      end
      ST_MEM: begin
        // Load data arrives one cycle after the address; keep the read up.
        memread = (dec_cls == CLS_LOAD);
        state_d = ST_UPDATE;
      end
      ST_UPDATE: state_d = ST_FETCH;
      ST_HALT:   halted  = 1'b1;
      default:   state_d = ST_FETCH;
    endcase
  end

  assign regdest  = lvl_q.regdest;
  assign alusrc   = lvl_q.alusrc;
  assign memtoreg = lvl_q.memtoreg;
  assign branch   = lvl_q.branch;
  assign jump     = lvl_q.jump;
endmodule

// File: tb/tb_control_fsm.sv
// Directed table-driven bench for control_fsm plus hand sequences for stall, halt and reset-mid-MEM.
module tb_control_fsm;
  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic        jump_signal;
  logic [15:0] dp_out;
  logic        imem_req;
  logic [7:0]  PC;
  logic [15:0] instruct_reg;
  logic        regdest, alusrc, memtoreg, branch, jump;
  logic        regwrite, memread, memwrite, halted, illegal_op;
  logic [15:0] retired_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  control_fsm dut (
    .clk(clk), .reset(reset), .imem_rdata(imem_rdata), .imem_valid(imem_valid),
    .jump_signal(jump_signal), .dp_out(dp_out), .imem_req(imem_req), .PC(PC),
    .instruct_reg(instruct_reg), .regdest(regdest), .alusrc(alusrc), .memtoreg(memtoreg),
    .branch(branch), .jump(jump), .regwrite(regwrite), .memread(memread),
    .memwrite(memwrite), .halted(halted), .illegal_op(illegal_op),
    .retired_count(retired_count)
  );

  typedef struct {
    string       name;
    logic [15:0] ins;
    logic        js;
    logic [15:0] dp;
    int          cyc, rw, mr, mw, ill;
    logic [4:0]  lvl;   // {regdest, alusrc, memtoreg, branch, jump} seen in EXEC
    logic [7:0]  pc;
    logic [15:0] ret;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(string name, logic [15:0] ins, logic js, logic [15:0] dp,
                              int cyc, int rw, int mr, int mw, int ill,
                              logic [4:0] lvl, logic [7:0] pc, logic [15:0] ret);
    vec_t v;
    v.name = name; v.ins = ins; v.js = js; v.dp = dp; v.cyc = cyc;
    v.rw = rw; v.mr = mr; v.mw = mw; v.ill = ill; v.lvl = lvl; v.pc = pc; v.ret = ret;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] strobes();
    return {regwrite, memread, memwrite, illegal_op, halted, imem_req};
  endfunction

  // Caller must be at a negedge with the DUT in FETCH; returns at the next FETCH negedge.
  task automatic run_instr(input logic [15:0] ins, input logic js, input logic [15:0] dp,
                           output int cyc, output int nrw, output int nmr, output int nmw,
                           output int nill, output logic [4:0] lvl, output int rw_at,
                           output bit excl_bad);
    cyc = 0; nrw = 0; nmr = 0; nmw = 0; nill = 0; lvl = '0; rw_at = 0; excl_bad = 1'b0;
    imem_rdata = ins; jump_signal = js; dp_out = dp; imem_valid = 1'b1;
    forever begin
      cyc++;
      if (regwrite) begin nrw++; rw_at = cyc; end
      if (memread) nmr++;
      if (memwrite) nmw++;
      if (illegal_op) nill++;
      if (int'(regwrite) + int'(memread) + int'(memwrite) > 1) excl_bad = 1'b1;
      if (cyc == 3) lvl = {regdest, alusrc, memtoreg, branch, jump};
      @(negedge clk);
      if (imem_req || cyc >= 20) break;
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_pc"}, PC, 8'h00);
    check({tag, "_ret"}, retired_count, 16'h0000);
    check({tag, "_ir"}, instruct_reg, 16'h0000);
    check({tag, "_strobes"}, strobes(), 6'b0);
    check({tag, "_levels"}, {regdest, alusrc, memtoreg, branch, jump}, 5'b0);
  endtask

  task automatic run_and_check(input vec_t v);
    int cyc, nrw, nmr, nmw, nill, rw_at;
    logic [4:0] lvl;
    bit excl_bad;
    run_instr(v.ins, v.js, v.dp, cyc, nrw, nmr, nmw, nill, lvl, rw_at, excl_bad);
    check({v.name, "_cycles"}, cyc, v.cyc);
    check({v.name, "_regwrite"}, nrw, v.rw);
    check({v.name, "_memread"}, nmr, v.mr);
    check({v.name, "_memwrite"}, nmw, v.mw);
    check({v.name, "_illegal"}, nill, v.ill);
    check({v.name, "_levels"}, lvl, v.lvl);
    check({v.name, "_pc"}, PC, v.pc);
    check({v.name, "_retired"}, retired_count, v.ret);
    check({v.name, "_exclusive"}, excl_bad, 1'b0);
    if (v.rw > 0) check({v.name, "_regwrite_cycle"}, rw_at, 3);
  endtask

  initial begin
    bit bad;
    logic [7:0] pc_h;

    //          name          ins       js  dp        cyc rw mr mw il lvl       pc     ret
    vq.push_back(mk("add0",     16'h0000, 0, 16'h0000, 4, 1, 0, 0, 0, 5'b10000, 8'h01, 16'd1));
    vq.push_back(mk("j5",       16'h000C, 1, 16'h0005, 4, 0, 0, 0, 0, 5'b00001, 8'h05, 16'd2));
    vq.push_back(mk("lw",       16'h0007, 0, 16'h0000, 5, 0, 2, 0, 0, 5'b01100, 8'h06, 16'd3));
    vq.push_back(mk("sw",       16'h0008, 1, 16'h0099, 5, 0, 0, 1, 0, 5'b01000, 8'h07, 16'd4));
    vq.push_back(mk("beqz_nt",  16'h000A, 0, 16'h0040, 4, 0, 0, 0, 0, 5'b00010, 8'h08, 16'd5));
    vq.push_back(mk("beq_t",    16'h000B, 1, 16'hAB12, 4, 0, 0, 0, 0, 5'b00010, 8'h12, 16'd6));
    vq.push_back(mk("add_stale",16'h1230, 1, 16'h0077, 4, 1, 0, 0, 0, 5'b10000, 8'h13, 16'd7));
    vq.push_back(mk("sll",      16'h0001, 0, 16'h0000, 4, 1, 0, 0, 0, 5'b10000, 8'h14, 16'd8));
    vq.push_back(mk("srl",      16'h0002, 0, 16'h0000, 4, 1, 0, 0, 0, 5'b10000, 8'h15, 16'd9));
    vq.push_back(mk("sub",      16'h0003, 0, 16'h0000, 4, 1, 0, 0, 0, 5'b10000, 8'h16, 16'd10));
    vq.push_back(mk("and",      16'h0004, 0, 16'h0000, 4, 1, 0, 0, 0, 5'b10000, 8'h17, 16'd11));
    vq.push_back(mk("or",       16'h0005, 0, 16'h0000, 4, 1, 0, 0, 0, 5'b10000, 8'h18, 16'd12));
    vq.push_back(mk("li",       16'h0006, 0, 16'h0000, 4, 1, 0, 0, 0, 5'b01000, 8'h19, 16'd13));
    vq.push_back(mk("addi",     16'hF0F9, 0, 16'h0000, 4, 1, 0, 0, 0, 5'b01000, 8'h1A, 16'd14));
    vq.push_back(mk("ill13",    16'h000D, 1, 16'h0050, 4, 0, 0, 0, 1, 5'b00000, 8'h1B, 16'd15));
    vq.push_back(mk("ill14",    16'h000E, 0, 16'h0000, 4, 0, 0, 0, 1, 5'b00000, 8'h1C, 16'd16));
    vq.push_back(mk("j_ff",     16'h000C, 1, 16'h00FF, 4, 0, 0, 0, 0, 5'b00001, 8'hFF, 16'd17));
    vq.push_back(mk("add_wrap", 16'h0000, 0, 16'h0000, 4, 1, 0, 0, 0, 5'b10000, 8'h00, 16'd18));
    vq.push_back(mk("j23",      16'h000C, 1, 16'h0023, 4, 0, 0, 0, 0, 5'b00001, 8'h23, 16'd19));

    reset = 1'b0; imem_rdata = 16'h0000; imem_valid = 1'b1; jump_signal = 1'b0; dp_out = 16'h0000;
    repeat (2) @(negedge clk);
    check_reset_state("reset0");
    reset = 1'b1;

    foreach (vq[i]) run_and_check(vq[i]);

    // Fetch stall: valid low for 7 cycles at PC 0x23.
    bad = 1'b0;
    imem_valid = 1'b0; imem_rdata = 16'h000D;
    for (int c = 0; c < 7; c++) begin
      if (strobes() !== 6'b000001 || PC !== 8'h23) bad = 1'b1;
      @(negedge clk);
    end
    check("stall_req_pc_quiet", bad, 1'b0);
    check("stall_retired", retired_count, 16'd19);
    run_and_check(mk("after_stall", 16'h0000, 0, 16'h0000, 4, 1, 0, 0, 0, 5'b10000, 8'h24, 16'd20));

    // Halt: frozen PC, one retirement, no strobes, jump_signal ignored.
    pc_h = PC;
    imem_rdata = 16'h000F; jump_signal = 1'b1; dp_out = 16'h0055;
    bad = 1'b0;
    for (int c = 1; c <= 24; c++) begin
      if (c == 3) check("halt_not_yet", halted, 1'b0);
      if (c == 4) check("halt_entry", halted, 1'b1);
      if (c >= 4 && (strobes() !== 6'b000010 || PC !== pc_h)) bad = 1'b1;
      @(negedge clk);
    end
    check("halt_frozen", bad, 1'b0);
    check("halt_pc", PC, 8'h24);
    check("halt_retired", retired_count, 16'd21);

    reset = 1'b0;
    @(negedge clk);
    check_reset_state("reset_halt");
    reset = 1'b1;
    run_and_check(mk("post_halt_add", 16'h0000, 0, 16'h0000, 4, 1, 0, 0, 0, 5'b10000, 8'h01, 16'd1));
    run_and_check(mk("post_halt_or",  16'h0005, 0, 16'h0000, 4, 1, 0, 0, 0, 5'b10000, 8'h02, 16'd2));

    // sw interrupted by reset during MEM.
    imem_rdata = 16'h0008; jump_signal = 1'b0; dp_out = 16'h0000;
    repeat (2) @(negedge clk);
    check("swmid_exec_memwrite", memwrite, 1'b1);
    @(negedge clk);
    check("swmid_mem_memwrite", memwrite, 1'b0);
    check("swmid_mem_alusrc", alusrc, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    check_reset_state("reset_mem");
    reset = 1'b1;
    run_and_check(mk("post_mem_add", 16'h0000, 0, 16'h0000, 4, 1, 0, 0, 0, 5'b10000, 8'h01, 16'd1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
